lab5_mcore_mem_net_xbar: RTL and testbench
==========================================

# lab5_mcore_mem_net_xbar

Single-bank request/response concentrator between four per-core cache-side upstream message adapters and the one memory-side downstream message adapter. It round-robin arbitrates the four network request streams onto one memory request stream and routes memory responses back by header destination. Each port has an outstanding-transaction counter, and the block raises a sticky error on a stray response. Instantiated once per cache→mem refill network in the multicore, with all upstream adapters in single-bank mode.

## Interface
- p_max_outstanding, default 4: max in-flight requests per source port; legal range 1–7, counter width 3 bits.
- p_num_ports, default 4: fixed at 4, equal to 2^c_net_srcdest_nbits.
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-low reset.
- req_in_val  input  4  per-port request valid.
- req_in_rdy  output  4  per-port request ready.
- req_in_hdr  input  4×net_hdr_t  per-port network header; src equals port index.
- req_in_payload  input  4×mem_req_16B_t  per-port request payload; opaque[7:6] carries the source.
- req_out_val / req_out_rdy  output / input  1 / 1  to downstream adapter.
- req_out_hdr / req_out_payload  output  net_hdr_t / mem_req_16B_t  granted message, unmodified.
- resp_in_val / resp_in_rdy  input / output  1 / 1  from downstream adapter.
- resp_in_hdr / resp_in_payload  input  net_hdr_t / mem_resp_16B_t.
- resp_out_val / resp_out_rdy  output / input  4 / 4  per-port response stream.
- resp_out_hdr / resp_out_payload  output  4×net_hdr_t / 4×mem_resp_16B_t  all ports driven with the head entry; only the selected port's val is asserted.
- err  output  1  sticky stray-response flag.

## Operation
- Request path: a round-robin arbiter feeds a 2-entry normal (non-bypass) request queue.
  - Eligible port i: req_in_val[i] && cnt[i] < p_max_outstanding.
  - Among eligible ports, grant the first found starting from rr_ptr and moving upward mod 4.
  - req_in_rdy[i] = grant[i] && !req_q_full. req_in_rdy is computed without depending on req_in_val of other ports through the full signal.
  - On a transfer (val && rdy) for port i: enqueue {hdr, payload}, set rr_ptr ← (i+1) mod 4, and increment cnt[i].
  - rr_ptr is unchanged in any cycle with no transfer.
- Response path: a 2-entry normal response queue.
  - resp_in_rdy = !resp_q_full.
  - Head destination d = head.hdr.dest.
  - resp_out_val[d] = !resp_q_empty; all other resp_out_val bits are 0.
  - Dequeue when resp_out_rdy[d] is high. Head-of-line blocking is intended.
  - On a dequeue to d: decrement cnt[d].
- Counter rules:
  - Increment and decrement of the same port in one cycle: cnt unchanged.
  - Dequeue to a port with cnt[d] == 0: cnt stays 0 (no wrap), the response is still delivered, and err ← 1.
  - err clears only on reset.
- Messages are never modified. Header and payload pass through bit-exact in both directions.

## Timing
- Reset values (reset low at posedge):
  - Both queues empty; rr_ptr = 0; all cnt = 0; err = 0.
  - req_out_val = 0, resp_out_val = 0000.
  - req_in_rdy = 0000 while reset is asserted; resp_in_rdy = 0 while reset is asserted.
- Reset mid-operation discards all queued messages. Outstanding counts are lost; this is intended.
- Latency:
  - Request: accepted at cycle N, req_out_val high in cycle N+1 at the earliest.
  - Response: same, 1-cycle minimum.
- Throughput: 1 message/cycle per direction when downstream is always ready. A full queue still accepts in the cycle it dequeues only if implemented as a pipe; the required behaviour is normal-queue semantics, i.e. no enqueue when full.
- All outputs are registered or derived from queue state, except req_in_rdy, which is combinational from arbiter state and req_in_val.

## Structure
- Shared package: net_hdr_t, mem_req_16B_t, mem_resp_16B_t, c_net_srcdest_nbits = 2, c_mem_opaque_nbits = 8.
- Sub-module lab5_mcore_net_queue2: 2-entry normal val/rdy queue parameterized on message width, instantiated twice.
- The round-robin arbiter is inline logic.

## Test plan
- Port 2 alone sends addr 0x1000, opaque 0x80 → req_out at the next cycle, bit-exact; then rr_ptr = 3 and cnt[2] = 1.
- All four ports valid continuously, req_out_rdy = 1 → grant order 0, 1, 2, 3, 0, …
- Port 1 sends 4 requests, no responses (p_max_outstanding = 4) → 5th request stalls with req_in_rdy[1] = 0. One response with dest = 1 → request accepted the next cycle.
- Response to dest 3 with resp_out_rdy[3] = 0 and a queued second response to dest 0 → neither delivered until rdy[3] rises; then dest 3, then dest 0, in order.
- Response to dest 2 with cnt[2] = 0 → delivered, cnt[2] stays 0, err = 1 and stays 1 until reset.
- Reset asserted with 2 messages queued each way → next cycle all val = 0, err = 0, rr_ptr = 0.

Source files
------------

// File: rtl/lab5_mcore_mem_net_xbar_pkg.sv
// Shared message types for the cache->mem refill network concentrator.
// Headers and memory messages are carried opaquely; only hdr.dest is inspected.
package lab5_mcore_mem_net_xbar_pkg;

  localparam int c_net_srcdest_nbits = 2;
  localparam int c_mem_opaque_nbits  = 8;

  typedef enum logic [2:0] {
    MEM_READ  = 3'd0,
    MEM_WRITE = 3'd1,
    MEM_INIT  = 3'd2,
    MEM_AMO   = 3'd3
  } mem_msg_type_e;

  typedef struct packed {
    logic [c_net_srcdest_nbits-1:0] src;
    logic [c_net_srcdest_nbits-1:0] dest;
  } net_hdr_t;

  typedef struct packed {
    mem_msg_type_e                 msg_type;
    logic [c_mem_opaque_nbits-1:0] opaque;
    logic [31:0]                   addr;
    logic [3:0]                    len;
    logic [127:0]                  data;
  } mem_req_16B_t;

  typedef struct packed {
    mem_msg_type_e                 msg_type;
    logic [c_mem_opaque_nbits-1:0] opaque;
    logic [1:0]                    test;
    logic [3:0]                    len;
    logic [127:0]                  data;
  } mem_resp_16B_t;

  localparam int c_req_msg_nbits  = $bits(net_hdr_t) + $bits(mem_req_16B_t);
  localparam int c_resp_msg_nbits = $bits(net_hdr_t) + $bits(mem_resp_16B_t);

endpackage

// File: rtl/lab5_mcore_net_queue2.sv
// Two-entry val/rdy queue with normal semantics: no enqueue while full,
// no bypass from enq to deq. Storage is left unreset; only pointers reset.
module lab5_mcore_net_queue2 #(
  parameter int p_msg_nbits = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enq_val,
  input  logic [p_msg_nbits-1:0] enq_msg,
  input  logic                   deq_rdy,
  output logic [p_msg_nbits-1:0] deq_msg,
  output logic                   full,
  output logic                   empty
);

  logic [p_msg_nbits-1:0] entry [2];
  logic                   wr_ptr;
  logic                   rd_ptr;
  logic [1:0]             count;
  logic                   enq_go;
  logic                   deq_go;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign enq_go  = enq_val && !full;
  assign deq_go  = deq_rdy && !empty;
  assign deq_msg = entry[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (enq_go) wr_ptr <= ~wr_ptr;
      if (deq_go) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, enq_go} - {1'b0, deq_go};
    end
  end

  always_ff @(posedge clk) begin
    if (enq_go) entry[wr_ptr] <= enq_msg;
  end

endmodule

// File: rtl/lab5_mcore_mem_net_xbar.sv
// Four-port round-robin request concentrator onto one memory port, with
// responses routed back by hdr.dest and per-port outstanding tracking.
module lab5_mcore_mem_net_xbar
  import lab5_mcore_mem_net_xbar_pkg::*;
#(
  parameter int p_max_outstanding = 4,
  parameter int p_num_ports       = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic          [p_num_ports-1:0]   req_in_val,
  output logic          [p_num_ports-1:0]   req_in_rdy,
  input  net_hdr_t      [p_num_ports-1:0]   req_in_hdr,
  input  mem_req_16B_t  [p_num_ports-1:0]   req_in_payload,
  output logic                              req_out_val,
  input  logic                              req_out_rdy,
  output net_hdr_t                          req_out_hdr,
  output mem_req_16B_t                      req_out_payload,
  input  logic                              resp_in_val,
  output logic                              resp_in_rdy,
  input  net_hdr_t                          resp_in_hdr,
  input  mem_resp_16B_t                     resp_in_payload,
  output logic          [p_num_ports-1:0]   resp_out_val,
  input  logic          [p_num_ports-1:0]   resp_out_rdy,
  output net_hdr_t      [p_num_ports-1:0]   resp_out_hdr,
  output mem_resp_16B_t [p_num_ports-1:0]   resp_out_payload,
  output logic                              err
);

  logic [c_net_srcdest_nbits-1:0] rr_ptr;
  logic [2:0]                     cnt [p_num_ports];
  logic [p_num_ports-1:0]         eligible;
  logic [p_num_ports-1:0]         grant;
  logic [c_net_srcdest_nbits-1:0] gidx;
  logic [c_net_srcdest_nbits-1:0] idx;
  logic                           found;
  logic [p_num_ports-1:0]         inc;
  logic [p_num_ports-1:0]         dec;
  logic                           req_xfer;
  logic                           resp_deq;

  logic                           req_q_full;
  logic                           req_q_empty;
  logic [c_req_msg_nbits-1:0]     req_q_head;
  logic                           resp_q_full;
  logic                           resp_q_empty;
  logic [c_resp_msg_nbits-1:0]    resp_q_head;
  net_hdr_t                       head_hdr;
  mem_resp_16B_t                  head_payload;

  always_comb begin
    for (int i = 0; i < p_num_ports; i++)
      eligible[i] = req_in_val[i] && (cnt[i] < 3'(p_max_outstanding));
  end

  // Search upward from rr_ptr; the first eligible port wins.
  always_comb begin
    grant = '0;
    gidx  = rr_ptr;
    idx   = rr_ptr;
    found = 1'b0;
    for (int k = 0; k < p_num_ports; k++) begin
      idx = rr_ptr + c_net_srcdest_nbits'(k);
      if (!found && eligible[idx]) begin
        grant[idx] = 1'b1;
        gidx       = idx;
        found      = 1'b1;
      end
    end
  end

  assign req_in_rdy = grant & {p_num_ports{reset && !req_q_full}};
  assign inc        = req_in_val & req_in_rdy;
  assign req_xfer   = |inc;

  lab5_mcore_net_queue2 #(.p_msg_nbits(c_req_msg_nbits)) req_q (
    .clk     (clk),
    .reset   (reset),
    .enq_val (req_xfer),
    .enq_msg ({req_in_hdr[gidx], req_in_payload[gidx]}),
    .deq_rdy (req_out_rdy),
    .deq_msg (req_q_head),
    .full    (req_q_full),
    .empty   (req_q_empty)
  );

  assign req_out_val                      = !req_q_empty;
  assign {req_out_hdr, req_out_payload}   = req_q_head;

  assign resp_in_rdy = reset && !resp_q_full;

  lab5_mcore_net_queue2 #(.p_msg_nbits(c_resp_msg_nbits)) resp_q (
    .clk     (clk),
    .reset   (reset),
    .enq_val (resp_in_val && resp_in_rdy),
    .enq_msg ({resp_in_hdr, resp_in_payload}),
    .deq_rdy (resp_out_rdy[head_hdr.dest]),
    .deq_msg (resp_q_head),
    .full    (resp_q_full),
    .empty   (resp_q_empty)
  );

  assign {head_hdr, head_payload} = resp_q_head;
  assign resp_out_hdr             = {p_num_ports{head_hdr}};
  assign resp_out_payload         = {p_num_ports{head_payload}};

  // Head-of-line blocking: only the head's destination is offered.
  always_comb begin
    resp_out_val                = '0;
    resp_out_val[head_hdr.dest] = !resp_q_empty;
  end

  assign dec      = resp_out_val & resp_out_rdy;
  assign resp_deq = |dec;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr <= '0;
      err    <= 1'b0;
      for (int i = 0; i < p_num_ports; i++) cnt[i] <= 3'd0;
    end else begin
      if (req_xfer) rr_ptr <= gidx + c_net_srcdest_nbits'(1);
      for (int i = 0; i < p_num_ports; i++) begin
        if (inc[i] && !dec[i])
          cnt[i] <= cnt[i] + 3'd1;
        else if (dec[i] && !inc[i] && cnt[i] != 3'd0)
          cnt[i] <= cnt[i] - 3'd1;
      end
      // A response to a port with nothing outstanding is still delivered.
      if (resp_deq && cnt[head_hdr.dest] == 3'd0) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lab5_mcore_mem_net_xbar.sv
// Directed bench for the refill-network concentrator: arbitration order,
// outstanding limits, response routing, stray-response flag and reset.
module tb_lab5_mcore_mem_net_xbar;
  import lab5_mcore_mem_net_xbar_pkg::*;

  logic                      clk;
  logic                      reset;
  logic          [3:0]       req_in_val;
  logic          [3:0]       req_in_rdy;
  net_hdr_t      [3:0]       req_in_hdr;
  mem_req_16B_t  [3:0]       req_in_payload;
  logic                      req_out_val;
  logic                      req_out_rdy;
  net_hdr_t                  req_out_hdr;
  mem_req_16B_t              req_out_payload;
  logic                      resp_in_val;
  logic                      resp_in_rdy;
  net_hdr_t                  resp_in_hdr;
  mem_resp_16B_t             resp_in_payload;
  logic          [3:0]       resp_out_val;
  logic          [3:0]       resp_out_rdy;
  net_hdr_t      [3:0]       resp_out_hdr;
  mem_resp_16B_t [3:0]       resp_out_payload;
  logic                      err;

  int n_checks = 0;
  int n_errors = 0;

  logic [3:0] exp_grant [6] = '{4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [1:0] exp_src   [6] = '{2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

  lab5_mcore_mem_net_xbar dut (
    .clk              (clk),
    .reset            (reset),
    .req_in_val       (req_in_val),
    .req_in_rdy       (req_in_rdy),
    .req_in_hdr       (req_in_hdr),
    .req_in_payload   (req_in_payload),
    .req_out_val      (req_out_val),
    .req_out_rdy      (req_out_rdy),
    .req_out_hdr      (req_out_hdr),
    .req_out_payload  (req_out_payload),
    .resp_in_val      (resp_in_val),
    .resp_in_rdy      (resp_in_rdy),
    .resp_in_hdr      (resp_in_hdr),
    .resp_in_payload  (resp_in_payload),
    .resp_out_val     (resp_out_val),
    .resp_out_rdy     (resp_out_rdy),
    .resp_out_hdr     (resp_out_hdr),
    .resp_out_payload (resp_out_payload),
    .err              (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic net_hdr_t mk_hdr(input logic [1:0] src, input logic [1:0] dest);
    mk_hdr.src  = src;
    mk_hdr.dest = dest;
  endfunction

  function automatic mem_req_16B_t mk_req(input logic [31:0] addr, input logic [7:0] opq,
                                          input logic [127:0] data);
    mk_req.msg_type = MEM_WRITE;
    mk_req.opaque   = opq;
    mk_req.addr     = addr;
    mk_req.len      = 4'd0;
    mk_req.data     = data;
  endfunction

  function automatic mem_resp_16B_t mk_resp(input logic [7:0] opq, input logic [127:0] data);
    mk_resp.msg_type = MEM_READ;
    mk_resp.opaque   = opq;
    mk_resp.test     = 2'b01;
    mk_resp.len      = 4'd0;
    mk_resp.data     = data;
  endfunction

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    reset           = 1'b0;
    req_in_val      = 4'hF;
    req_out_rdy     = 1'b0;
    resp_in_val     = 1'b1;
    resp_in_hdr     = mk_hdr(2'd0, 2'd0);
    resp_in_payload = mk_resp(8'h00, 128'h0);
    resp_out_rdy    = 4'h0;
    for (int i = 0; i < 4; i++) begin
      req_in_hdr[i]     = mk_hdr(2'(i), 2'd0);
      req_in_payload[i] = mk_req(32'h2000 + 32'(i) * 32'h100, {2'(i), 6'h00},
                                 {96'h0, 32'hA5A5_0000 + 32'(i)});
    end
    req_in_payload[2] = mk_req(32'h1000, 8'h80, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);

    // Reset state, with inputs valid so the ready gating is exercised.
    tick();
    tick();
    check("rst_req_in_rdy",   req_in_rdy,   4'b0000);
    check("rst_resp_in_rdy",  resp_in_rdy,  1'b0);
    check("rst_req_out_val",  req_out_val,  1'b0);
    check("rst_resp_out_val", resp_out_val, 4'b0000);
    check("rst_err",          err,          1'b0);
    req_in_val  = 4'h0;
    resp_in_val = 1'b0;
    reset       = 1'b1;
    tick();

    // Port 2 alone: bit-exact pass-through one cycle later.
    req_in_val = 4'b0100;
    #1;
    check("p2_rdy", req_in_rdy, 4'b0100);
    tick();
    req_in_val = 4'b0000;
    check("p2_out_val", req_out_val, 1'b1);
    check("p2_out_hdr", req_out_hdr, mk_hdr(2'd2, 2'd0));
    check("p2_out_payload", req_out_payload,
          mk_req(32'h1000, 8'h80, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210));
    req_out_rdy = 1'b1;
    tick();
    check("p2_drained", req_out_val, 1'b0);

    // All four ports valid: rr_ptr was left at 3, so order is 3,0,1,2,3,0.
    req_in_val = 4'hF;
    for (int k = 0; k < 6; k++) begin
      #1;
      check($sformatf("rr_grant_%0d", k), req_in_rdy, exp_grant[k]);
      tick();
      check($sformatf("rr_out_val_%0d", k), req_out_val, 1'b1);
      check($sformatf("rr_out_src_%0d", k), req_out_hdr.src, exp_src[k]);
    end
    req_in_val = 4'h0;
    tick();
    check("rr_drained", req_out_val, 1'b0);

    // Port 1 outstanding limit, released by one response.
    do_reset();
    req_out_rdy = 1'b1;
    req_in_val  = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("lim_rdy_%0d", k), req_in_rdy, 4'b0010);
      tick();
    end
    check("lim_stall", req_in_rdy, 4'b0000);
    resp_out_rdy    = 4'hF;
    resp_in_val     = 1'b1;
    resp_in_hdr     = mk_hdr(2'd0, 2'd1);
    resp_in_payload = mk_resp(8'h40, 128'h1111_2222);
    #1;
    check("lim_resp_in_rdy", resp_in_rdy, 1'b1);
    tick();
    resp_in_val = 1'b0;
    check("lim_resp_val", resp_out_val, 4'b0010);
    check("lim_resp_hdr", resp_out_hdr[1], mk_hdr(2'd0, 2'd1));
    check("lim_resp_payload", resp_out_payload[1], mk_resp(8'h40, 128'h1111_2222));
    check("lim_still_stall", req_in_rdy, 4'b0000);
    tick();
    check("lim_release", req_in_rdy, 4'b0010);
    check("lim_resp_gone", resp_out_val, 4'b0000);
    tick();
    check("lim_stall_again", req_in_rdy, 4'b0000);
    check("lim_err", err, 1'b0);
    req_in_val = 4'h0;

    // Head-of-line blocking on dest 3 with dest 0 queued behind it.
    do_reset();
    req_out_rdy  = 1'b1;
    resp_out_rdy = 4'h0;
    req_in_val   = 4'b1001;
    #1;
    check("hol_grant0", req_in_rdy, 4'b0001);
    tick();
    check("hol_grant3", req_in_rdy, 4'b1000);
    tick();
    req_in_val      = 4'h0;
    resp_in_val     = 1'b1;
    resp_in_hdr     = mk_hdr(2'd0, 2'd3);
    resp_in_payload = mk_resp(8'hC0, 128'hAAAA);
    tick();
    resp_in_hdr     = mk_hdr(2'd0, 2'd0);
    resp_in_payload = mk_resp(8'h00, 128'hBBBB);
    tick();
    resp_in_val = 1'b0;
    check("hol_full", resp_in_rdy, 1'b0);
    check("hol_head_val", resp_out_val, 4'b1000);
    resp_out_rdy = 4'b0001;
    tick();
    check("hol_blocked", resp_out_val, 4'b1000);
    check("hol_head_payload", resp_out_payload[3], mk_resp(8'hC0, 128'hAAAA));
    resp_out_rdy = 4'hF;
    tick();
    check("hol_second_val", resp_out_val, 4'b0001);
    check("hol_second_payload", resp_out_payload[0], mk_resp(8'h00, 128'hBBBB));
    tick();
    check("hol_empty", resp_out_val, 4'b0000);
    check("hol_err", err, 1'b0);

    // Stray response to port 2: delivered, err sticks, count stays at zero.
    do_reset();
    resp_out_rdy    = 4'hF;
    resp_in_val     = 1'b1;
    resp_in_hdr     = mk_hdr(2'd0, 2'd2);
    resp_in_payload = mk_resp(8'h80, 128'h5555);
    tick();
    resp_in_val = 1'b0;
    check("stray_val", resp_out_val, 4'b0100);
    check("stray_err_before", err, 1'b0);
    tick();
    check("stray_err", err, 1'b1);
    check("stray_gone", resp_out_val, 4'b0000);
    req_out_rdy = 1'b1;
    req_in_val  = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("stray_cnt_rdy_%0d", k), req_in_rdy, 4'b0100);
      tick();
    end
    check("stray_cnt_limit", req_in_rdy, 4'b0000);
    req_in_val = 4'h0;
    tick();
    tick();
    check("stray_err_sticky", err, 1'b1);

    // Reset with two messages queued in each direction.
    req_out_rdy     = 1'b0;
    resp_out_rdy    = 4'h0;
    req_in_val      = 4'b0011;
    resp_in_val     = 1'b1;
    resp_in_hdr     = mk_hdr(2'd0, 2'd0);
    resp_in_payload = mk_resp(8'h00, 128'h7777);
    tick();
    tick();
    req_in_val  = 4'h0;
    resp_in_val = 1'b0;
    check("pre_rst_req_val",  req_out_val,  1'b1);
    check("pre_rst_resp_val", resp_out_val, 4'b0001);
    check("pre_rst_req_full", req_in_rdy,   4'b0000);
    reset       = 1'b0;
    req_in_val  = 4'hF;
    resp_in_val = 1'b1;
    tick();
    check("mid_rst_req_val",  req_out_val,  1'b0);
    check("mid_rst_resp_val", resp_out_val, 4'b0000);
    check("mid_rst_err",      err,          1'b0);
    check("mid_rst_req_rdy",  req_in_rdy,   4'b0000);
    check("mid_rst_resp_rdy", resp_in_rdy,  1'b0);
    reset       = 1'b1;
    req_in_val  = 4'h0;
    resp_in_val = 1'b0;
    tick();
    check("post_rst_req_val",  req_out_val,  1'b0);
    check("post_rst_resp_val", resp_out_val, 4'b0000);
    req_in_val = 4'hF;
    #1;
    check("post_rst_rr_ptr", req_in_rdy, 4'b0001);
    req_in_val = 4'h0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
